// File: rtl/om_hazard_tracker_pkg.sv
// OM hazard tracker shared types and helpers.
// Position width, slot record and lane compare.
package om_hazard_tracker_pkg;

  localparam int OM_DIM_BITS = 12;
  localparam int OM_LANES    = 4;

  typedef logic [OM_DIM_BITS-1:0] om_pos_t;

  typedef struct packed {
    logic                            valid;
    logic [OM_LANES-1:0]             mask;
    logic [OM_LANES*OM_DIM_BITS-1:0] pos_x;
    logic [OM_LANES*OM_DIM_BITS-1:0] pos_y;
  } om_slot_t;

  function automatic logic om_pos_eq(
    input om_pos_t ax,
    input om_pos_t ay,
    input om_pos_t bx,
    input om_pos_t by
  );
    return (ax == bx) && (ay == by);
  endfunction

endpackage

// File: rtl/om_hazard_tracker_match.sv
// OM hazard comparator tree.
// Flags any active input pixel that hits an in-flight slot.
module om_hazard_tracker_match
  import om_hazard_tracker_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int NUM_SLOTS = 8
) (
  input  logic [NUM_LANES-1:0]             in_mask,
  input  logic [NUM_LANES*OM_DIM_BITS-1:0] in_pos_x,
  input  logic [NUM_LANES*OM_DIM_BITS-1:0] in_pos_y,
  input  logic [NUM_SLOTS-1:0]             slot_valid,
  input  logic [NUM_SLOTS*NUM_LANES-1:0]   slot_mask,
  input  logic [NUM_SLOTS*NUM_LANES*OM_DIM_BITS-1:0] slot_pos_x,
  input  logic [NUM_SLOTS*NUM_LANES*OM_DIM_BITS-1:0] slot_pos_y,
  output logic                             hazard
);

  localparam int D = OM_DIM_BITS;

  // Any valid slot / active lane pair at the same (x,y).
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        for (int j = 0; j < NUM_LANES; j++) begin
          if (slot_valid[s] && in_mask[i] &&
              slot_mask[s*NUM_LANES+j] &&
              om_pos_eq(in_pos_x[i*D +: D],
                        in_pos_y[i*D +: D],
                        slot_pos_x[(s*NUM_LANES+j)*D +: D],
                        slot_pos_y[(s*NUM_LANES+j)*D +: D]))
            hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/om_hazard_tracker.sv
// OM hazard tracker top.
// Allocates in-flight slots and stalls overlapping requests.
module om_hazard_tracker
  import om_hazard_tracker_pkg::*;
#(
  parameter int NUM_LANES = OM_LANES,
  parameter int NUM_SLOTS = 8,
  parameter int DATAW     = 32,
  parameter int SLOT_BITS = $clog2(NUM_SLOTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [NUM_LANES-1:0]             in_mask,
  input  logic [NUM_LANES*OM_DIM_BITS-1:0] in_pos_x,
  input  logic [NUM_LANES*OM_DIM_BITS-1:0] in_pos_y,
  input  logic [DATAW-1:0]                 in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [NUM_LANES-1:0]             out_mask,
  output logic [NUM_LANES*OM_DIM_BITS-1:0] out_pos_x,
  output logic [NUM_LANES*OM_DIM_BITS-1:0] out_pos_y,
  output logic [DATAW-1:0]                 out_data,
  output logic [SLOT_BITS-1:0]             out_tag,
  input  logic                             out_ready,
  input  logic                             release_valid,
  input  logic [SLOT_BITS-1:0]             release_tag,
  output logic                             idle,
  output logic                             full
);

  localparam int PW = NUM_LANES * OM_DIM_BITS;

  logic [NUM_SLOTS-1:0]           r_slot_valid;
  logic [NUM_SLOTS*NUM_LANES-1:0] r_slot_mask;
  logic [NUM_SLOTS*PW-1:0]        r_slot_x;
  logic [NUM_SLOTS*PW-1:0]        r_slot_y;

  logic                 r_out_valid;
  logic [NUM_LANES-1:0] r_out_mask;
  logic [PW-1:0]        r_out_x;
  logic [PW-1:0]        r_out_y;
  logic [DATAW-1:0]     r_out_data;
  logic [SLOT_BITS-1:0] r_out_tag;

  logic                 w_hazard;
  logic                 w_full;
  logic                 w_fire;
  logic [SLOT_BITS-1:0] w_free_idx;

  om_hazard_tracker_match #(
    .NUM_LANES (NUM_LANES),
    .NUM_SLOTS (NUM_SLOTS)
  ) u_match (
    .in_mask    (in_mask),
    .in_pos_x   (in_pos_x),
    .in_pos_y   (in_pos_y),
    .slot_valid (r_slot_valid),
    .slot_mask  (r_slot_mask),
    .slot_pos_x (r_slot_x),
    .slot_pos_y (r_slot_y),
    .hazard     (w_hazard)
  );

  assign w_full   = &r_slot_valid;
  assign in_ready = ~w_hazard & ~w_full &
                    (~r_out_valid | out_ready);
  assign w_fire   = in_valid & in_ready;

  // Lowest-index free slot; only used when not full.
  always_comb begin
    w_free_idx = '0;
    for (int s = NUM_SLOTS-1; s >= 0; s--) begin
      if (!r_slot_valid[s])
        w_free_idx = SLOT_BITS'(s);
    end
  end

  // Slot table: release first, allocation overrides.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_valid <= '0;
      r_slot_mask  <= '0;
      r_slot_x     <= '0;
      r_slot_y     <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (release_valid &&
            release_tag == SLOT_BITS'(s))
          r_slot_valid[s] <= 1'b0;
        if (w_fire && w_free_idx == SLOT_BITS'(s)) begin
          r_slot_valid[s] <= 1'b1;
          r_slot_mask[s*NUM_LANES +: NUM_LANES] <= in_mask;
          r_slot_x[s*PW +: PW] <= in_pos_x;
          r_slot_y[s*PW +: PW] <= in_pos_y;
        end
      end
    end
  end

  // Output register: load on fire, drain on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_mask  <= in_mask;
      r_out_x     <= in_pos_x;
      r_out_y     <= in_pos_y;
      r_out_data  <= in_data;
      r_out_tag   <= w_free_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_mask  = r_out_mask;
  assign out_pos_x = r_out_x;
  assign out_pos_y = r_out_y;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign full      = w_full;
  assign idle      = ~(|r_slot_valid) & ~r_out_valid;

`ifndef SYNTHESIS
  logic [1:0] r_rst_hold;

  // Quiet window after reset for stale releases.
  always_ff @(posedge clk) begin
    if (reset)
      r_rst_hold <= 2'd2;
    else if (r_rst_hold != 2'd0)
      r_rst_hold <= r_rst_hold - 2'd1;
  end

  // Releasing a slot that is not in flight is a bug.
  always_ff @(posedge clk) begin
    if (!reset && r_rst_hold == 2'd0 && release_valid)
      assert (r_slot_valid[release_tag])
        else $error("release of free slot %0d",
                    release_tag);
  end
`endif

endmodule

// File: tb/tb_om_hazard_tracker.sv
// Scoreboard bench for om_hazard_tracker.
// Directed requests, queue-based output checking.
module tb_om_hazard_tracker;

  localparam int D  = 12;
  localparam int NL = 4;
  localparam int PW = NL * D;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [3:0]    in_mask;
  logic [PW-1:0] in_pos_x;
  logic [PW-1:0] in_pos_y;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [3:0]    out_mask;
  logic [PW-1:0] out_pos_x;
  logic [PW-1:0] out_pos_y;
  logic [31:0]   out_data;
  logic [2:0]    out_tag;
  logic          out_ready;
  logic          release_valid;
  logic [2:0]    release_tag;
  logic          idle;
  logic          full;

  typedef struct packed {
    logic [3:0]    m;
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic [31:0]   d;
    logic [2:0]    t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  om_hazard_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_mask       (in_mask),
    .in_pos_x      (in_pos_x),
    .in_pos_y      (in_pos_y),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_mask      (out_mask),
    .out_pos_x     (out_pos_x),
    .out_pos_y     (out_pos_y),
    .out_data      (out_data),
    .out_tag       (out_tag),
    .out_ready     (out_ready),
    .release_valid (release_valid),
    .release_tag   (release_tag),
    .idle          (idle),
    .full          (full)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pk(
    input int a0, input int a1,
    input int a2, input int a3
  );
    return {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0]    m,
                       input logic [PW-1:0] x,
                       input logic [PW-1:0] y,
                       input logic [31:0]   d,
                       input logic [2:0]    t,
                       input int            exp_wait);
    int w;
    bit got;
    exp_t e;
    w = 0;
    got = 1'b0;
    in_valid = 1'b1;
    in_mask  = m;
    in_pos_x = x;
    in_pos_y = y;
    in_data  = d;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else begin
        w++;
        sync();
      end
    end
    checks++;
    if (!got || w != exp_wait) begin
      errors++;
      $display("FAIL issue_wait d=%0h: got %0d ready=%0b need %0d",
               d, w, got, exp_wait);
    end
    if (got) begin
      e.m = m; e.x = x; e.y = y; e.d = d; e.t = t;
      q.push_back(e);
    end
    sync();
    in_valid = 1'b0;
  endtask

  task automatic do_release(input logic [2:0] t);
    release_valid = 1'b1;
    release_tag   = t;
    sync();
    release_valid = 1'b0;
  endtask

  // Monitor: every accepted output pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (!reset && out_valid && out_ready) begin
      a.m = out_mask; a.x = out_pos_x; a.y = out_pos_y;
      a.d = out_data; a.t = out_tag;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %0h expected none", a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL out_txn: got %0h expected %0h", a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_mask = '0;
    in_pos_x = '0;
    in_pos_y = '0;
    in_data = '0;
    out_ready = 1'b1;
    release_valid = 1'b0;
    release_tag = '0;
    repeat (2) sync();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_oval", 64'(out_valid), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    sync();

    issue(4'hF, pk(0, 1, 2, 3), pk(0, 0, 0, 0),
          32'hA, 3'd0, 0);
    @(negedge clk);
    chk("a_idle", 64'(idle), 64'd0);
    chk("a_oval", 64'(out_valid), 64'd1);
    sync();

    release_valid = 1'b1;
    release_tag = 3'd0;
    fork
      begin
        sync();
        release_valid = 1'b0;
      end
    join_none
    issue(4'b0001, pk(2, 9, 9, 9), pk(0, 9, 9, 9),
          32'hB, 3'd0, 1);

    issue(4'b0001, pk(5, 2, 7, 7), pk(5, 0, 7, 7),
          32'hC, 3'd1, 0);

    do_release(3'd0);
    do_release(3'd1);
    @(negedge clk);
    chk("rel_idle", 64'(idle), 64'd1);
    sync();

    for (int k = 0; k < 8; k++) begin
      if (k == 5)
        issue(4'hF, pk(80, 80, 80, 80), pk(5, 5, 5, 5),
              32'h100 + 32'(k), 3'(k), 0);
      else
        issue(4'hF,
              pk(16*k, 16*k+1, 16*k+2, 16*k+3),
              pk(k, k, k, k),
              32'h100 + 32'(k), 3'(k), 0);
    end
    @(negedge clk);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_rdy", 64'(in_ready), 64'd0);
    sync();

    do_release(3'd3);
    @(negedge clk);
    chk("r3_full", 64'(full), 64'd0);
    sync();
    issue(4'hF, pk(200, 201, 202, 203), pk(1, 1, 1, 1),
          32'h33, 3'd3, 0);

    do_release(3'd4);
    out_ready = 1'b0;
    issue(4'hF, pk(300, 301, 302, 303), pk(2, 2, 2, 2),
          32'hD4, 3'd4, 0);
    release_valid = 1'b1;
    release_tag = 3'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_oval", 64'(out_valid), 64'd1);
      chk("hold_tag", 64'(out_tag), 64'd4);
      chk("hold_data", 64'(out_data), 64'hD4);
      chk("hold_x", 64'(out_pos_x),
          64'(pk(300, 301, 302, 303)));
      chk("hold_rdy", 64'(in_ready), 64'd0);
      chk("hold_full", 64'(full), (c == 0) ? 64'd1 : 64'd0);
      sync();
      release_valid = 1'b0;
    end
    out_ready = 1'b1;

    do_release(3'd1);
    do_release(3'd2);
    do_release(3'd3);
    out_ready = 1'b0;
    issue(4'hF, pk(100, 101, 102, 103), pk(9, 9, 9, 9),
          32'hE0, 3'd0, 0);
    @(negedge clk);
    chk("pre_oval", 64'(out_valid), 64'd1);
    chk("pre_idle", 64'(idle), 64'd0);
    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_idle", 64'(idle), 64'd1);
    chk("mid_full", 64'(full), 64'd0);
    chk("mid_oval", 64'(out_valid), 64'd0);
    sync();
    out_ready = 1'b1;
    issue(4'hF, pk(100, 101, 64, 65), pk(9, 9, 4, 4),
          32'hF0, 3'd0, 0);

    repeat (3) @(negedge clk);
    chk("q_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
